full_sub_1_bit: RTL and testbench

//  - Clocked 1-bit full subtractor: computes x - y - cin, giving difference bit dif and borrow-out cout.
//  - Leaf cell of the subtractor library; chained LSB-to-MSB by multi-bit subtractors (cout -> next cin).
//  - Arithmetic is combinational in a core sub-module; results are registered with a valid strobe.

---
 rtl/sub_pkg.sv | 34 +++
 rtl/full_sub_1_bit_core.sv | 23 ++
 rtl/full_sub_1_bit.sv | 122 ++++++++++++
 tb/tb_full_sub_1_bit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_pkg
// Description : Shared types and constants for the subtractor cell library.
//               Optional feature macro used by the library:
//               FULL_SUB_1_BIT_SERIAL_EN (bit-serial borrow chaining).
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    // One subtractor result: difference bit and borrow-out.
    typedef struct packed {
        logic dif;
        logic cout;
    } sub_bits_t;

    // Value every result register takes under reset.
    localparam logic c_SUB_RST_DIF  = 1'b0;
    localparam logic c_SUB_RST_COUT = 1'b0;

    // Legal range of the output pipeline depth.
    localparam int c_PIPE_STAGES_MIN = 1;
    localparam int c_PIPE_STAGES_MAX = 2;

    // Reset value of a result register, packed as a struct.
    function automatic sub_bits_t sub_rst_value();
        sub_bits_t v;
        v.dif  = c_SUB_RST_DIF;
        v.cout = c_SUB_RST_COUT;
        return v;
    endfunction

endpackage : sub_pkg
`default_nettype wire

// File: rtl/full_sub_1_bit_core.sv
`default_nettype none
// ============================================================================
// Module      : full_sub_1_bit_core
// Description : Purely combinational 1-bit full subtractor, x - y - cin.
//               dif is the difference bit, cout is the borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
module full_sub_1_bit_core (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic dif,
    output logic cout
);

    // Difference is odd parity; borrow when the subtrahend side outweighs x.
    always_comb begin
        dif  = x ^ y ^ cin;
        cout = (~x & y) | (~x & cin) | (y & cin);
    end

endmodule : full_sub_1_bit_core
`default_nettype wire

// File: rtl/full_sub_1_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_sub_1_bit
// Description : Clocked 1-bit full subtractor leaf cell. The arithmetic lives
//               in full_sub_1_bit_core; this level adds PIPE_STAGES result
//               registers with a matching valid pipeline.
//               Optional feature: define FULL_SUB_1_BIT_SERIAL_EN to add the
//               serial/first ports and an internal borrow register for
//               LSB-first bit-serial subtraction over consecutive valid beats.
// Revision    : 1.0 - initial release
// ============================================================================
module full_sub_1_bit
    import sub_pkg::*;
#(
    parameter int PIPE_STAGES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic in_valid,
`ifdef FULL_SUB_1_BIT_SERIAL_EN
    input  logic serial,
    input  logic first,
`endif
    output logic dif,
    output logic cout,
    output logic out_valid
);

    // Depth outside the supported range is rejected at elaboration.
    if ((PIPE_STAGES < c_PIPE_STAGES_MIN) || (PIPE_STAGES > c_PIPE_STAGES_MAX)) begin : g_bad_pipe_stages
        $error("full_sub_1_bit: PIPE_STAGES must be 1 or 2");
    end

    logic      core_cin;
    sub_bits_t core_res;

    full_sub_1_bit_core u_core (
        .x    (x),
        .y    (y),
        .cin  (core_cin),
        .dif  (core_res.dif),
        .cout (core_res.cout)
    );

`ifdef FULL_SUB_1_BIT_SERIAL_EN
    logic brw_q;
    logic brw_d;

    // Serial mode takes the borrow from the previous beat except on the LSB beat.
    always_comb begin
        core_cin = cin;
        brw_d    = brw_q;
        if (serial) begin
            core_cin = first ? cin : brw_q;
            if (in_valid) begin
                brw_d = core_res.cout;
            end
        end
    end

    // Borrow carried between beats of a serial word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            brw_q <= 1'b0;
        end else begin
            brw_q <= brw_d;
        end
    end
`else
    // Parallel-only build: borrow-in always comes straight from the port.
    always_comb begin
        core_cin = cin;
    end
`endif

    sub_bits_t [PIPE_STAGES-1:0] stage_q;
    sub_bits_t [PIPE_STAGES-1:0] stage_d;
    logic      [PIPE_STAGES-1:0] vld_q;
    logic      [PIPE_STAGES-1:0] vld_d;

    // Shift valids every cycle; data moves only with a valid so outputs hold
    // their last result across bubbles and X on idle inputs never lands.
    always_comb begin
        stage_d  = stage_q;
        vld_d    = '0;
        vld_d[0] = in_valid;
        if (in_valid) begin
            stage_d[0] = core_res;
        end
        for (int i = 1; i < PIPE_STAGES; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Result and valid pipeline; reset clears every stage and drops in-flight beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                stage_q[i] <= sub_rst_value();
            end
            vld_q <= '0;
        end else begin
            stage_q <= stage_d;
            vld_q   <= vld_d;
        end
    end

    // The last stage drives the outputs.
    always_comb begin
        dif       = stage_q[PIPE_STAGES-1].dif;
        cout      = stage_q[PIPE_STAGES-1].cout;
        out_valid = vld_q[PIPE_STAGES-1];
    end

endmodule : full_sub_1_bit
`default_nettype wire

// File: tb/tb_full_sub_1_bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_sub_1_bit
// Description : Self-checking bench for full_sub_1_bit. Expected results are
//               queued as beats are driven and popped when the DUT output for
//               that cycle is due. Serial tests run when
//               FULL_SUB_1_BIT_SERIAL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_sub_1_bit;

    localparam int PIPE_STAGES = 1;

    typedef struct {
        logic v;
        logic d;
        logic c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic x, y, cin, in_valid;
    logic serial, first;
    logic dif, cout, out_valid;

    int tests = 0;
    int fails = 0;

    // Reference truth tables indexed by {x, y, cin}.
    logic [7:0] tt_dif  = 8'b1001_0110;
    logic [7:0] tt_cout = 8'b1000_1110;

    exp_t sb[$];
    logic m_dif, m_cout, m_brw;

    always #5 clk = ~clk;

    full_sub_1_bit #(
        .PIPE_STAGES (PIPE_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .in_valid  (in_valid),
`ifdef FULL_SUB_1_BIT_SERIAL_EN
        .serial    (serial),
        .first     (first),
`endif
        .dif       (dif),
        .cout      (cout),
        .out_valid (out_valid)
    );

    // Drive one cycle, queue its expected output, advance one clock and pop
    // the expectation that is due now (if any).
    task automatic step(input logic v, input logic xi, input logic yi, input logic ci,
                        input logic ser, input logic fst,
                        output logic have, output exp_t e);
        exp_t       n;
        logic [2:0] idx;
        logic       eff;
        in_valid = v;
        x        = xi;
        y        = yi;
        cin      = ci;
        serial   = ser;
        first    = fst;
        if (v) begin
            eff = ci;
`ifdef FULL_SUB_1_BIT_SERIAL_EN
            if (ser) eff = fst ? ci : m_brw;
`endif
            idx    = {xi, yi, eff};
            m_dif  = tt_dif[idx];
            m_cout = tt_cout[idx];
`ifdef FULL_SUB_1_BIT_SERIAL_EN
            if (ser) m_brw = m_cout;
`endif
        end
        n.v = v;
        n.d = m_dif;
        n.c = m_cout;
        sb.push_back(n);
        @(posedge clk);
        #1;
        have = 1'b0;
        e    = '{1'b0, 1'b0, 1'b0};
        if (sb.size() >= PIPE_STAGES) begin
            e    = sb.pop_front();
            have = 1'b1;
        end
    endtask

    // Hold reset for some cycles (optionally with a valid 111 beat presented)
    // and check every stage reads zero, then release with a fresh scoreboard.
    task automatic apply_reset(input int cycles, input logic with_beat, input string name);
        rst_n    = 1'b0;
        in_valid = with_beat;
        x        = with_beat ? 1'b1 : 1'bx;
        y        = with_beat ? 1'b1 : 1'bx;
        cin      = with_beat ? 1'b1 : 1'bx;
        serial   = 1'b0;
        first    = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if ({out_valid, dif, cout} !== 3'b000) begin
                fails++;
                $display("FAIL %s cycle %0d: v/dif/cout got %b%b%b expected 000",
                         name, i, out_valid, dif, cout);
            end
            in_valid = 1'b0;
        end
        sb.delete();
        m_dif  = 1'b0;
        m_cout = 1'b0;
        m_brw  = 1'b0;
        for (int i = 1; i < PIPE_STAGES; i++) sb.push_back('{1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(2, 1'b0, "reset");
    endtask

    task automatic test_exhaustive();
        logic have;
        exp_t e;
        logic [2:0] v3;
        for (int i = 0; i < 8 + PIPE_STAGES; i++) begin
            v3 = 3'(i);
            if (i < 8) step(1'b1, v3[2], v3[1], v3[0], 1'b0, 1'b0, have, e);
            else       step(1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b0, have, e);
            if (have) begin
                tests++;
                if ({out_valid, dif, cout} !== {e.v, e.d, e.c}) begin
                    fails++;
                    $display("FAIL exhaustive step %0d: v/dif/cout got %b%b%b expected %b%b%b",
                             i, out_valid, dif, cout, e.v, e.d, e.c);
                end
            end
        end
    endtask

    task automatic test_bubble();
        logic have;
        exp_t e;
        logic [3:0] vt  = 4'b0101;   // valid for steps 0..3 (bit i)
        logic [3:0] xt  = 4'b0100;
        logic [3:0] yt  = 4'b0001;
        logic [3:0] ct  = 4'b0001;
        for (int i = 0; i < 3 + PIPE_STAGES; i++) begin
            if (i < 3) step(vt[i], xt[i], yt[i], ct[i], 1'b0, 1'b0, have, e);
            else       step(1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b0, have, e);
            if (have) begin
                tests++;
                if ({out_valid, dif, cout} !== {e.v, e.d, e.c}) begin
                    fails++;
                    $display("FAIL bubble step %0d: v/dif/cout got %b%b%b expected %b%b%b",
                             i, out_valid, dif, cout, e.v, e.d, e.c);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic have;
        exp_t e;
        logic v;
        for (int i = 0; i < 32; i++) begin
            v = (i < 30) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
            step(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, 1'b0, have, e);
            if (have) begin
                tests++;
                if ({out_valid, dif, cout} !== {e.v, e.d, e.c}) begin
                    fails++;
                    $display("FAIL back_to_back step %0d: v/dif/cout got %b%b%b expected %b%b%b",
                             i, out_valid, dif, cout, e.v, e.d, e.c);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic have;
        exp_t e;
        // Leave a nonzero held result behind so the reset is observable.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, have, e);
        apply_reset(1, 1'b1, "reset_midstream");
        for (int i = 0; i < 1 + PIPE_STAGES; i++) begin
            if (i == 0) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, have, e);
            else        step(1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b0, have, e);
            if (have) begin
                tests++;
                if ({out_valid, dif, cout} !== {e.v, e.d, e.c}) begin
                    fails++;
                    $display("FAIL post_reset step %0d: v/dif/cout got %b%b%b expected %b%b%b",
                             i, out_valid, dif, cout, e.v, e.d, e.c);
                end
            end
        end
    endtask

`ifdef FULL_SUB_1_BIT_SERIAL_EN
    task automatic test_serial(input logic [3:0] a, input logic [3:0] b, input string name);
        logic have;
        exp_t e;
        for (int i = 0; i < 4 + PIPE_STAGES; i++) begin
            if (i < 4) step(1'b1, a[i], b[i], 1'b0, 1'b1, (i == 0), have, e);
            else       step(1'b0, 1'bx, 1'bx, 1'bx, 1'b1, 1'b0, have, e);
            if (have) begin
                tests++;
                if ({out_valid, dif, cout} !== {e.v, e.d, e.c}) begin
                    fails++;
                    $display("FAIL %s step %0d: v/dif/cout got %b%b%b expected %b%b%b",
                             name, i, out_valid, dif, cout, e.v, e.d, e.c);
                end
            end
        end
        serial = 1'b0;
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        serial   = 1'b0;
        first    = 1'b0;
        m_dif    = 1'b0;
        m_cout   = 1'b0;
        m_brw    = 1'b0;
        test_reset();
        test_exhaustive();
        test_bubble();
        test_back_to_back();
        test_reset_midstream();
`ifdef FULL_SUB_1_BIT_SERIAL_EN
        test_serial(4'b0101, 4'b0011, "serial");
        test_serial(4'b0000, 4'b0001, "serial_underflow");
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_full_sub_1_bit
`default_nettype wire
